nand4_stim_sequencer: RTL
=========================

// Module: nand4_stim_sequencer
// PURPOSE
//  Stimulus controller for one 4-input NAND gate under test in the power characterisation benches.
//  It drives the gate inputs through a selected vector sequence for a programmed number of passes.
//  It samples the gate output after a settle window and counts vectors, output toggles and
//  functional mismatches against ~&DRV. Start/done handshake to the bench supervisor.
// PARAMETERS
//  CNT_W       16  width of REPS and of all result counters
//  SETTLE_CYC  2   cycles each vector is held before QN_OBS is sampled (legal >= 1)
// PORTS
//  CLK      in   1       clock, all state on rising edge
//  RSTB     in   1       asynchronous active-low reset
//  START    in   1       run request; accepted only in IDLE
//  MODE     in   2       sequence select, captured at accepted START
//  SEL      in   2       toggled input for MODE=2 (0 = IN1 .. 3 = IN4), captured at START
//  REPS     in   CNT_W   number of passes, captured at START
//  QN_OBS   in   1       observed gate output
//  DRV      out  4       gate inputs; bit0 = IN1 .. bit3 = IN4 (registered)
//  BUSY     out  1       high in SETTLE/SAMPLE
//  DONE     out  1       one-cycle pulse in FINISH
//  VEC_CNT  out  CNT_W   vectors sampled this run
//  TOG_CNT  out  CNT_W   QN_OBS transitions between consecutive samples
//  ERR_CNT  out  CNT_W   samples where QN_OBS != ~&DRV
// BEHAVIOUR
//  Reset values: DRV=4'h0, BUSY=0, DONE=0, all counters=0, prev_qn=1, state IDLE.
//  FSM states:
//   IDLE. On START with REPS!=0: capture inputs, clear counters, set prev_qn=1,
//         DRV<=vector 0, go to SETTLE. On START with REPS=0: clear counters, go to FINISH; DRV unchanged.
//   SETTLE. Hold DRV for SETTLE_CYC cycles, then go to SAMPLE.
//   SAMPLE. One cycle:
//    - VEC_CNT++; ERR_CNT++ if QN_OBS != ~&DRV; TOG_CNT++ if QN_OBS != prev_qn; prev_qn<=QN_OBS.
//    - If this is not the last vector of the last pass: DRV<=next vector, go to SETTLE.
//    - Else: DRV<=4'h0, go to FINISH.
//   FINISH. DONE=1 for one cycle, then IDLE.
//  Vector sequences (one pass; i is the index within the pass):
//   MODE=0: 16 vectors, binary i = 0..15.
//   MODE=1: 16 vectors, Gray code i^(i>>1).
//   MODE=2: 2 vectors. 4'hF with bit SEL cleared, then 4'hF.
//   MODE=3: 1 vector, 4'hF.
//  Pass handling: the index wraps to 0 at the end of a pass and the remaining-pass count decrements.
//  The run ends when the last vector of pass REPS is sampled.
//  Timing: each vector occupies SETTLE_CYC+1 cycles. DONE is asserted exactly
//   N_vec*REPS*(SETTLE_CYC+1) cycles after the START-accepting edge.
//  Counters saturate at all-ones and hold their values after DONE until the next accepted START.
//  START while not IDLE is ignored; it is neither queued nor allowed to alter captured MODE/SEL/REPS.
//  Input changes to MODE/SEL/REPS mid-run have no effect.
//  RSTB low mid-run immediately forces all reset values, including DRV=0; no DONE is generated.
// STRUCTURE
//  Package nand4_seq_pkg:
//   - mode localparams MODE_BIN/MODE_GRAY/MODE_TOG/MODE_HOLD
//   - state enum (IDLE, SETTLE, SAMPLE, FINISH)
//   - function n_vec(mode), returning the pass length.
//  Sub-module nand4_vec_gen: combinational (mode, sel, idx[3:0]) -> vec[3:0]; no state.
//  Top level holds the FSM, settle counter, pass/index counters, prev_qn and result counters.
// TESTING (SETTLE_CYC=2, QN_OBS driven by an ideal NAND of DRV unless stated)
//  1. MODE=0, REPS=1 -> VEC=16, TOG=1, ERR=0; DONE 48 cycles after START edge; DRV=0 after.
//  2. MODE=0, REPS=2 -> VEC=32, TOG=3, ERR=0.
//  3. MODE=2, SEL=0, REPS=3 -> DRV E,F,E,F,E,F; VEC=6, TOG=5, ERR=0; DONE after 18 cycles.
//  4. QN_OBS tied 1, MODE=1, REPS=1 -> VEC=16, ERR=1 (vector 4'hF only), TOG=0.
//  5. REPS=0 -> DONE one cycle after START, BUSY never high, counters 0.
//     START pulsed mid-run -> ignored, results as in test 1.
//  6. RSTB low during SETTLE of MODE=0 run -> DRV=0, BUSY=0, counters 0, no DONE;
//     a new START then runs normally.

Source files
------------

// File: rtl/nand4_seq_pkg.sv
// Shared types and helpers for the 4-input NAND stimulus sequencer.
package nand4_seq_pkg;

  localparam logic [1:0] MODE_BIN  = 2'd0;
  localparam logic [1:0] MODE_GRAY = 2'd1;
  localparam logic [1:0] MODE_TOG  = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Number of vectors in one pass of the given sequence.
  function automatic logic [4:0] n_vec(input logic [1:0] mode);
    case (mode)
      MODE_BIN, MODE_GRAY: n_vec = 5'd16;
      MODE_TOG:            n_vec = 5'd2;
      default:             n_vec = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/nand4_vec_gen.sv
// Combinational vector generator: maps (mode, sel, index within pass) to gate inputs.
module nand4_vec_gen
  import nand4_seq_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [1:0] sel,
  input  logic [3:0] idx,
  output logic [3:0] vec
);

  // NOTE: every output of an always_comb gets a default first so no path infers a latch.
  always_comb begin
    vec = 4'hF;
    case (mode)
      MODE_BIN:  vec = idx;
      MODE_GRAY: vec = idx ^ (idx >> 1);
      MODE_TOG:  vec = idx[0] ? 4'hF : (4'hF & ~(4'b0001 << sel));
      default:   vec = 4'hF;
    endcase
  end

endmodule

// File: rtl/nand4_stim_sequencer.sv
// Drives a 4-input NAND under test through a vector sequence for a number of passes,
// sampling its output after a settle window and counting vectors, toggles and errors.
module nand4_stim_sequencer
  import nand4_seq_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [1:0]       sel,
  input  logic [CNT_W-1:0] reps,
  input  logic             qn_obs,
  output logic [3:0]       drv,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] tog_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t           state, state_nxt;
  logic [1:0]       mode_q, sel_q;
  logic [CNT_W-1:0] pass_left;
  logic [3:0]       idx, idx_nxt;
  logic [SW-1:0]    settle_cnt;
  logic             prev_qn;
  logic             settle_done, idx_last, last_vec, qn_err;
  logic [1:0]       gen_mode, gen_sel;
  logic [3:0]       gen_idx, gen_vec;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign settle_done = (settle_cnt == SW'(SETTLE_CYC - 1));
  assign idx_last    = ({1'b0, idx} == n_vec(mode_q) - 5'd1);
  assign last_vec    = idx_last && (pass_left == CNT_W'(1));
  assign idx_nxt     = idx_last ? 4'd0 : idx + 4'd1;
  assign qn_err      = (qn_obs != ~&drv);

  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = (state == FINISH);

  // In IDLE the generator previews vector 0 of the requested sequence.
  always_comb begin
    gen_mode = mode_q;
    gen_sel  = sel_q;
    gen_idx  = idx_nxt;
    if (state == IDLE) begin
      gen_mode = mode;
      gen_sel  = sel;
      gen_idx  = 4'd0;
    end
  end

  nand4_vec_gen u_vec_gen (
    .mode (gen_mode),
    .sel  (gen_sel),
    .idx  (gen_idx),
    .vec  (gen_vec)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (reps != '0) ? SETTLE : FINISH;
      SETTLE:  if (settle_done) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_vec ? FINISH : SETTLE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      drv        <= 4'h0;
      mode_q     <= MODE_BIN;
      sel_q      <= 2'd0;
      pass_left  <= '0;
      idx        <= 4'd0;
      settle_cnt <= '0;
      prev_qn    <= 1'b1;
      vec_cnt    <= '0;
      tog_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          vec_cnt <= '0;
          tog_cnt <= '0;
          err_cnt <= '0;
          prev_qn <= 1'b1;
          if (reps != '0) begin
            mode_q     <= mode;
            sel_q      <= sel;
            pass_left  <= reps;
            idx        <= 4'd0;
            settle_cnt <= '0;
            drv        <= gen_vec;
          end
        end
        SETTLE: settle_cnt <= settle_cnt + SW'(1);
        SAMPLE: begin
          settle_cnt <= '0;
          vec_cnt    <= sat_inc(vec_cnt);
          if (qn_err)            err_cnt <= sat_inc(err_cnt);
          if (qn_obs != prev_qn) tog_cnt <= sat_inc(tog_cnt);
          prev_qn <= qn_obs;
          if (last_vec) begin
            drv <= 4'h0;
          end else begin
            drv <= gen_vec;
            idx <= idx_nxt;
            if (idx_last) pass_left <= pass_left - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
